multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
- Parametrised multicycle control FSM for the 8-bit CPU family; generation after the fixed 2-byte-fetch main decoder.
- Adds a variable-length instruction fetch, a memory ready handshake with a timeout, a load path, and a wider ALU function set.
- Adds branch-on-zero and branch-on-nonzero, a resumable HALT, and a sticky TRAP for illegal opcodes and bus errors.
- Sits between the IR/opcode register and the datapath muxes, enables and ALU.

Parameters:
DATA_W, 8, width of aluout (zero-detect width)
FETCH_BYTES, 2, instruction bytes fetched per instruction (1..4); width of ir_en
WAIT_TIMEOUT, 16, consecutive not-ready cycles before bus error; 0 disables timeout
CNT_W, 5, wait counter width; must satisfy 2^CNT_W > WAIT_TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode  in  4  latched IR1[7:4]; valid from DECODE onward
aluout  in  DATA_W  ALU result, used for branch condition
mem_ready  in  1  memory completes the current request this cycle
resume  in  1  leave HALT
pc_sel  out  1  1 = branch target to PC
pc_en  out  1  PC write enable
adr_sel  out  1  0 = PC address, 1 = data address
mem_req  out  1  memory request
mem_we  out  1  write qualifier for mem_req
ir_en  out  FETCH_BYTES  one-hot IR byte enable
reg_sel  out  1  1 = ALU-format destination field
wd3_sel  out  1  1 = ALU result, 0 = memory data
reg_write  out  1  register file write enable
op1_sel  out  1  0 = PC, 1 = register
op2_sel  out  1  1 = constant 1, 0 = register
alu_out_en  out  1  ALU output register enable
alu_control  out  3  ALU function
halted  out  1  in HALT
trap  out  1  in TRAP (sticky)
bus_error  out  1  trap cause was timeout (sticky)

Behaviour:
- States: FETCH, DECODE, MEM, LOADWB, EXEC, BRANCH, HALT, TRAP.
- Registers:
  - Fetch byte index idx (0..FETCH_BYTES-1).
  - Wait counter wcnt (CNT_W bits).
  - bus_error flag.
- Reset, synchronous: state=FETCH, idx=0, wcnt=0, bus_error=0.
- Output defaults: all outputs 0, except alu_control=010 and op2_sel=0. Each state below overrides only what it lists.
- FETCH:
  - Always: mem_req=1, adr_sel=0.
  - When mem_ready=1: ir_en[idx]=1, pc_en=1, op1_sel=0, op2_sel=1, alu_control=010 (PC+1).
  - Last byte (idx==FETCH_BYTES-1) with ready: next DECODE, idx cleared to 0.
  - Otherwise, ready increments idx.
- DECODE: all outputs at default; one cycle. Next state by opcode:
  - 0000 (load) or 0001 (store) -> MEM.
  - 01xx -> EXEC.
  - 1000, 1001, 1010 -> BRANCH.
  - 1011 -> HALT.
  - 0010, 0011, 11xx -> TRAP, bus_error stays 0.
- MEM:
  - Always: adr_sel=1, mem_req=1, mem_we=opcode[0].
  - On mem_ready: load -> LOADWB; store -> FETCH.
- LOADWB: reg_write=1, wd3_sel=0, reg_sel=0; next FETCH.
- EXEC:
  - Outputs: op1_sel=1, op2_sel=0, alu_out_en=1, reg_sel=1, wd3_sel=1, reg_write=1.
  - alu_control by opcode[1:0]: 00->010 add, 01->110 sub, 10->000 and, 11->001 or.
  - Next FETCH.
- BRANCH:
  - Outputs: op1_sel=1, op2_sel=0, alu_control=110.
  - taken = jump (1000), OR beq (1001) with aluout==0, OR bne (1010) with aluout!=0.
  - pc_sel=taken, pc_en=taken. Next FETCH.
- HALT: halted=1; resume=1 -> FETCH next cycle, else stay.
- TRAP: trap=1; exit only via reset.
- Wait counter:
  - In FETCH/MEM with mem_ready=0: wcnt increments.
  - Cleared on mem_ready=1 and on every state change.
  - WAIT_TIMEOUT!=0 and wcnt==WAIT_TIMEOUT-1 with mem_ready=0: next TRAP, bus_error<=1.
  - mem_ready=1 in that same cycle: completes normally, no trap.
- Enables are qualified by mem_ready: no ir_en/pc_en while waiting, so a stall never double-increments PC.
- reset has priority over resume, mem_ready and timeout, including mid-fetch (idx cleared) and in TRAP/HALT.
- Latency with zero-wait memory, FETCH_BYTES=2:
  - ALU op and branch: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- Reset, mem_ready=1, opcode=0100 -> FETCH ir_en=01 then 10, DECODE, EXEC (alu_control=010, reg_write=1) -> FETCH on cycle 5.
- opcode=1001: aluout=0 -> BRANCH pc_sel=1, pc_en=1. aluout=8'h05 -> pc_sel=0, pc_en=0. opcode=1010 with aluout=8'h05 -> taken.
- Load with mem_ready low 3 cycles in MEM -> mem_req=1, adr_sel=1 held 4 cycles, then LOADWB reg_write=1, wd3_sel=0.
- WAIT_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, trap=1, bus_error=1. Held until reset; reset -> FETCH, both 0.
- opcode=1011 -> halted=1 for 10 cycles with no pc_en; resume pulse -> FETCH next cycle.
- opcode=1100 -> TRAP, bus_error=0. FETCH_BYTES=1 build: ir_en=1 once per instruction.

Source files
------------

// File: rtl/multicycle_ctrl_unit_if.sv
// Control bus between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_unit_if #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FETCH_BYTES = 2
);
  logic [3:0]             opcode;
  logic [DATA_W-1:0]      aluout;
  logic                   mem_ready;
  logic                   resume;
  logic                   pc_sel;
  logic                   pc_en;
  logic                   adr_sel;
  logic                   mem_req;
  logic                   mem_we;
  logic [FETCH_BYTES-1:0] ir_en;
  logic                   reg_sel;
  logic                   wd3_sel;
  logic                   reg_write;
  logic                   op1_sel;
  logic                   op2_sel;
  logic                   alu_out_en;
  logic [2:0]             alu_control;
  logic                   halted;
  logic                   trap;
  logic                   bus_error;

  modport master (
    input  opcode, aluout, mem_ready, resume,
    output pc_sel, pc_en, adr_sel, mem_req, mem_we, ir_en, reg_sel, wd3_sel,
           reg_write, op1_sel, op2_sel, alu_out_en, alu_control, halted, trap,
           bus_error
  );

  modport slave (
    output opcode, aluout, mem_ready, resume,
    input  pc_sel, pc_en, adr_sel, mem_req, mem_we, ir_en, reg_sel, wd3_sel,
           reg_write, op1_sel, op2_sel, alu_out_en, alu_control, halted, trap,
           bus_error
  );
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control FSM: variable-length fetch, ready/timeout handshake,
// load/store, ALU ops, conditional branches, resumable HALT and sticky TRAP.
module multicycle_ctrl_unit #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FETCH_BYTES  = 2,
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_ctrl_unit_if.master     bus
);

  localparam int unsigned IDX_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam logic [FETCH_BYTES-1:0] IR_ONE   = FETCH_BYTES'(1);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(FETCH_BYTES - 1);
  localparam logic [CNT_W-1:0]       WCNT_MAX = CNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM, S_LOADWB, S_EXEC, S_BRANCH, S_HALT, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             bus_error_q, bus_error_d;
  logic             timeout_c;
  logic             taken_c;

  // Last tolerated not-ready cycle; WAIT_TIMEOUT of zero never expires.
  assign timeout_c = (WAIT_TIMEOUT != 0) && (wcnt_q == WCNT_MAX);

  assign taken_c = (bus.opcode == 4'b1000) ||
                   ((bus.opcode == 4'b1001) && (bus.aluout == DATA_W'(0))) ||
                   ((bus.opcode == 4'b1010) && (bus.aluout != DATA_W'(0)));

  // Next-state and output decode.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    wcnt_d          = '0;
    bus_error_d     = bus_error_q;
    bus.pc_sel      = 1'b0;
    bus.pc_en       = 1'b0;
    bus.adr_sel     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.ir_en       = '0;
    bus.reg_sel     = 1'b0;
    bus.wd3_sel     = 1'b0;
    bus.reg_write   = 1'b0;
    bus.op1_sel     = 1'b0;
    bus.op2_sel     = 1'b0;
    bus.alu_out_en  = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.halted      = 1'b0;
    bus.trap        = 1'b0;
    bus.bus_error   = bus_error_q;

    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          // Enables only on completion so a stall never re-increments PC.
          bus.ir_en   = IR_ONE << idx_q;
          bus.pc_en   = 1'b1;
          bus.op2_sel = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_DECODE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timeout_c) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        casez (bus.opcode)
          4'b000?:                     state_d = S_MEM;
          4'b01??:                     state_d = S_EXEC;
          4'b1000, 4'b1001, 4'b1010:   state_d = S_BRANCH;
          4'b1011:                     state_d = S_HALT;
          default:                     state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        bus.adr_sel = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = bus.opcode[0];
        if (bus.mem_ready) begin
          state_d = bus.opcode[0] ? S_FETCH : S_LOADWB;
        end else if (timeout_c) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_LOADWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXEC: begin
        bus.op1_sel    = 1'b1;
        bus.alu_out_en = 1'b1;
        bus.reg_sel    = 1'b1;
        bus.wd3_sel    = 1'b1;
        bus.reg_write  = 1'b1;
        case (bus.opcode[1:0])
          2'b00:   bus.alu_control = ALU_ADD;
          2'b01:   bus.alu_control = ALU_SUB;
          2'b10:   bus.alu_control = ALU_AND;
          default: bus.alu_control = ALU_OR;
        endcase
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.op1_sel     = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_sel      = taken_c;
        bus.pc_en       = taken_c;
        state_d         = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.resume) state_d = S_FETCH;
      end
      default: begin
        bus.trap = 1'b1;
      end
    endcase
  end

  // State registers; reset overrides every other condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      idx_q       <= '0;
      wcnt_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: a 2-byte-fetch instance with a short
// timeout and a 1-byte-fetch instance with the timeout disabled.
module tb_multicycle_ctrl_unit;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  multicycle_ctrl_unit_if #(.DATA_W(8), .FETCH_BYTES(2)) bus_a ();
  multicycle_ctrl_unit_if #(.DATA_W(8), .FETCH_BYTES(1)) bus_b ();

  multicycle_ctrl_unit #(.DATA_W(8), .FETCH_BYTES(2), .WAIT_TIMEOUT(4), .CNT_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  multicycle_ctrl_unit #(.DATA_W(8), .FETCH_BYTES(1), .WAIT_TIMEOUT(0), .CNT_W(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_sel,pc_en,adr_sel,mem_req,mem_we}_{ir_en}_{reg_sel,wd3_sel,reg_write}
  // _{op1_sel,op2_sel,alu_out_en}_{alu_control}_{halted,trap,bus_error}
  localparam logic [18:0] DEF     = 19'b00000_00_000_000_010_000;
  localparam logic [18:0] F_WAIT  = 19'b00010_00_000_000_010_000;
  localparam logic [18:0] F_RDY0  = 19'b01010_01_000_010_010_000;
  localparam logic [18:0] F_RDY1  = 19'b01010_10_000_010_010_000;
  localparam logic [18:0] MEM_LD  = 19'b00110_00_000_000_010_000;
  localparam logic [18:0] MEM_ST  = 19'b00111_00_000_000_010_000;
  localparam logic [18:0] LOADWB  = 19'b00000_00_001_000_010_000;
  localparam logic [18:0] EXEC_0  = 19'b00000_00_111_101_000_000;
  localparam logic [18:0] BR_T    = 19'b11000_00_000_100_110_000;
  localparam logic [18:0] BR_N    = 19'b00000_00_000_100_110_000;
  localparam logic [18:0] HALTV   = 19'b00000_00_000_000_010_100;
  localparam logic [18:0] TRAPV   = 19'b00000_00_000_000_010_010;
  localparam logic [18:0] TRAP_BE = 19'b00000_00_000_000_010_011;

  function automatic logic [18:0] outs_a();
    return {bus_a.pc_sel, bus_a.pc_en, bus_a.adr_sel, bus_a.mem_req, bus_a.mem_we,
            bus_a.ir_en, bus_a.reg_sel, bus_a.wd3_sel, bus_a.reg_write,
            bus_a.op1_sel, bus_a.op2_sel, bus_a.alu_out_en, bus_a.alu_control,
            bus_a.halted, bus_a.trap, bus_a.bus_error};
  endfunction

  // {ir_en, pc_en, mem_req, reg_write, trap, bus_error}
  function automatic logic [5:0] outs_b();
    return {bus_b.ir_en, bus_b.pc_en, bus_b.mem_req, bus_b.reg_write, bus_b.trap,
            bus_b.bus_error};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus_a.mem_ready = 1'b1;
    bus_a.resume    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b0;
    bus_a.resume = 1'b0;
    #1;
    n_run++;
    if (outs_a() !== F_RDY0) begin
      n_fail++;
      $display("FAIL reset_a: got %b want %b", outs_a(), F_RDY0);
    end
    n_run++;
    if (outs_b() !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_b: got %b want %b", outs_b(), 6'b001000);
    end
  endtask

  task automatic test_alu_ops();
    logic [18:0] ev [4];
    logic [2:0]  alu_tab [4];
    alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001};
    for (int op = 0; op < 4; op++) begin
      bus_a.opcode    = 4'b0100 | 4'(op);
      bus_a.mem_ready = 1'b1;
      ev = '{F_RDY0, F_RDY1, DEF, EXEC_0 | {13'b0, alu_tab[op], 3'b0}};
      for (int c = 0; c < 4; c++) begin
        #1;
        n_run++;
        if (outs_a() !== ev[c]) begin
          n_fail++;
          $display("FAIL alu op%0d cyc%0d: got %b want %b", op, c, outs_a(), ev[c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] opc [5];
    logic [7:0] alu [5];
    logic       tk  [5];
    logic [18:0] ev [4];
    opc = '{4'b1001, 4'b1001, 4'b1010, 4'b1010, 4'b1000};
    alu = '{8'h00,   8'h05,   8'h05,   8'h00,   8'h05};
    tk  = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
    for (int v = 0; v < 5; v++) begin
      bus_a.opcode    = opc[v];
      bus_a.aluout    = alu[v];
      bus_a.mem_ready = 1'b1;
      ev = '{F_RDY0, F_RDY1, DEF, tk[v] ? BR_T : BR_N};
      for (int c = 0; c < 4; c++) begin
        #1;
        n_run++;
        if (outs_a() !== ev[c]) begin
          n_fail++;
          $display("FAIL branch v%0d cyc%0d: got %b want %b", v, c, outs_a(), ev[c]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load_store();
    logic [18:0] ev [12];
    logic        rv [12];
    ev = '{F_RDY0, F_RDY1, DEF, MEM_LD, MEM_LD, MEM_LD, MEM_LD, LOADWB,
           F_RDY0, F_RDY1, DEF, MEM_ST};
    rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      bus_a.opcode    = (c < 8) ? 4'b0000 : 4'b0001;
      bus_a.mem_ready = rv[c];
      #1;
      n_run++;
      if (outs_a() !== ev[c]) begin
        n_fail++;
        $display("FAIL ldst cyc%0d: got %b want %b", c, outs_a(), ev[c]);
      end
      @(negedge clk);
    end
  endtask

  // Three stalls then ready on the last tolerated cycle: no trap, no lost byte.
  task automatic test_fetch_stall();
    logic [18:0] ev [7];
    logic        rv [7];
    ev = '{F_WAIT, F_WAIT, F_WAIT, F_RDY0, F_RDY1, DEF, EXEC_0 | 19'b010_000};
    rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus_a.opcode = 4'b0100;
    for (int c = 0; c < 7; c++) begin
      bus_a.mem_ready = rv[c];
      #1;
      n_run++;
      if (outs_a() !== ev[c]) begin
        n_fail++;
        $display("FAIL stall cyc%0d: got %b want %b", c, outs_a(), ev[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [18:0] ev [7];
    logic        rv [7];
    ev = '{F_WAIT, F_WAIT, F_WAIT, F_WAIT, TRAP_BE, TRAP_BE, TRAP_BE};
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus_a.opcode = 4'b0100;
    bus_a.resume = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus_a.mem_ready = rv[c];
      #1;
      n_run++;
      if (outs_a() !== ev[c]) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: got %b want %b", c, outs_a(), ev[c]);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus_a.resume = 1'b0;
    #1;
    n_run++;
    if (outs_a() !== F_RDY0) begin
      n_fail++;
      $display("FAIL timeout_reset: got %b want %b", outs_a(), F_RDY0);
    end
  endtask

  task automatic test_halt();
    logic [18:0] ev [14];
    for (int c = 0; c < 14; c++) ev[c] = HALTV;
    ev[0] = F_RDY0;
    ev[1] = F_RDY1;
    ev[2] = DEF;
    bus_a.opcode    = 4'b1011;
    bus_a.mem_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus_a.resume = (c == 13);
      #1;
      n_run++;
      if (outs_a() !== ev[c]) begin
        n_fail++;
        $display("FAIL halt cyc%0d: got %b want %b", c, outs_a(), ev[c]);
      end
      @(negedge clk);
    end
    bus_a.resume = 1'b0;
    #1;
    n_run++;
    if (outs_a() !== F_RDY0) begin
      n_fail++;
      $display("FAIL halt_resume: got %b want %b", outs_a(), F_RDY0);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  opc [3];
    logic [18:0] ev [6];
    opc = '{4'b1100, 4'b0010, 4'b1111};
    ev  = '{F_RDY0, F_RDY1, DEF, TRAPV, TRAPV, TRAPV};
    for (int v = 0; v < 3; v++) begin
      bus_a.opcode    = opc[v];
      bus_a.mem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        bus_a.resume = (c >= 3);
        #1;
        n_run++;
        if (outs_a() !== ev[c]) begin
          n_fail++;
          $display("FAIL illegal v%0d cyc%0d: got %b want %b", v, c, outs_a(), ev[c]);
        end
        @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      bus_a.resume = 1'b0;
      #1;
      n_run++;
      if (outs_a() !== F_RDY0) begin
        n_fail++;
        $display("FAIL illegal_reset v%0d: got %b want %b", v, outs_a(), F_RDY0);
      end
    end
  endtask

  // Reset after the first fetch byte must restart at byte 0.
  task automatic test_reset_midfetch();
    bus_a.opcode    = 4'b0100;
    bus_a.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_run++;
    if (outs_a() !== F_RDY1) begin
      n_fail++;
      $display("FAIL midfetch_pre: got %b want %b", outs_a(), F_RDY1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_run++;
    if (outs_a() !== F_RDY0) begin
      n_fail++;
      $display("FAIL midfetch_post: got %b want %b", outs_a(), F_RDY0);
    end
  endtask

  task automatic test_fetch1();
    logic [5:0] ev [7];
    logic [3:0] opc [7];
    bus_b.mem_ready = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    n_run++;
    if (outs_b() !== 6'b001000) begin
      n_fail++;
      $display("FAIL fetch1_nowait: got %b want %b", outs_b(), 6'b001000);
    end
    ev  = '{6'b111000, 6'b000000, 6'b000100, 6'b111000, 6'b000000, 6'b010000, 6'b111000};
    opc = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
    bus_b.mem_ready = 1'b1;
    bus_b.aluout    = 8'h00;
    for (int c = 0; c < 7; c++) begin
      bus_b.opcode = opc[c];
      #1;
      n_run++;
      if (outs_b() !== ev[c]) begin
        n_fail++;
        $display("FAIL fetch1 cyc%0d: got %b want %b", c, outs_b(), ev[c]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_run           = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus_a.opcode    = 4'b0000;
    bus_a.aluout    = 8'h00;
    bus_a.mem_ready = 1'b0;
    bus_a.resume    = 1'b0;
    bus_b.opcode    = 4'b0000;
    bus_b.aluout    = 8'h00;
    bus_b.mem_ready = 1'b0;
    bus_b.resume    = 1'b0;

    test_reset();
    test_alu_ops();
    test_branch();
    test_load_store();
    test_fetch_stall();
    test_timeout();
    test_halt();
    test_illegal();
    test_reset_midfetch();
    test_fetch1();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
